// File: rtl/ps2_game_keys.sv
// PS/2 keyboard front end: synchronise, glitch-filter, deserialise frames and track game-key make/break state.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_game_keys #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TIMEOUT_US = 200,
    parameter int FILT_LEN   = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] key_held,
    output logic [6:0] key_press,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);
    localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int WD_W   = $clog2(TO_CYC + 1);
    localparam int FC_W   = $clog2(FILT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_STOP} state_t;

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            filt_q, filt_d;
    logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;
    logic            fall, din;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_ok_q, par_ok_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [7:0]      scan_code_q, scan_code_d;
    logic            scan_valid_q, scan_valid_d;
    logic            frame_err_q, frame_err_d;

    logic            ext_q, ext_d, brk_q, brk_d;
    logic [6:0]      held_q, held_d, press_q, press_d, mask;

    function automatic logic [6:0] key_mask(input logic [7:0] code);
        case (code)
            8'h1D:   return 7'h01;
            8'h1B:   return 7'h02;
            8'h1C:   return 7'h04;
            8'h23:   return 7'h08;
            8'h1A:   return 7'h10;
            8'h22:   return 7'h20;
            8'h5A:   return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Filtered clock only follows the synchronised input after FILT_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FC_W'(FILT_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_q & ~filt_d;
    assign din  = dat_sync_q[1];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        wdog_d       = '0;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d   = S_SHIFT;
                        bit_cnt_d = '0;
                    end
                end
                S_SHIFT: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_ok_d = ^{shift_q, din};
`else
                    par_ok_d = 1'b1;
`endif
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (din && par_ok_q) begin
                        scan_code_d  = shift_q;
                        scan_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // Edge-free cycles inside a frame: abandon the frame once the gap reaches the timeout.
            if (wdog_q == WD_W'(TO_CYC - 1)) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        held_d  = held_q;
        press_d = '0;
        mask    = key_mask(scan_code_q);
        if (scan_valid_q) begin
            if (scan_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (scan_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (!ext_q) begin
                    held_d  = brk_q ? (held_q & ~mask) : (held_q | mask);
                    press_d = brk_q ? 7'h00 : (mask & ~held_q);
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            wdog_q       <= '0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            held_q       <= '0;
            press_q      <= '0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk};
            dat_sync_q   <= {dat_sync_q[0], ps2_data};
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            wdog_q       <= wdog_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            held_q       <= held_d;
            press_q      <= press_d;
        end
    end

    assign key_held   = held_q;
    assign key_press  = press_q;
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_game_keys.sv
// Scoreboard bench for ps2_game_keys; clocked at a scaled CLK_HZ so a 200-cycle watchdog stands for 200 us.
module tb_ps2_game_keys;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [6:0] key_held, key_press;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    always #5 clk = ~clk;

    ps2_game_keys #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FILT_LEN(8)) dut (
        .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_held(key_held), .key_press(key_press), .scan_code(scan_code),
        .scan_valid(scan_valid), .frame_err(frame_err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0, fe_cnt = 0, fe_cyc = 0, last_edge_cyc = 0, fe0 = 0;
    int unsigned press_cnt [7];
    int unsigned exp_press [7];
    logic [7:0]  sb_q [$];
    logic        m_ext = 1'b0, m_brk = 1'b0;
    logic [6:0]  m_held = '0;
    int unsigned exp_fe = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] model_map(input logic [7:0] b);
        logic [6:0] m;
        m = '0;
        if (b == 8'h1D) m[0] = 1'b1;
        if (b == 8'h1B) m[1] = 1'b1;
        if (b == 8'h1C) m[2] = 1'b1;
        if (b == 8'h23) m[3] = 1'b1;
        if (b == 8'h1A) m[4] = 1'b1;
        if (b == 8'h22) m[5] = 1'b1;
        if (b == 8'h5A) m[6] = 1'b1;
        return m;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            if (scan_valid) begin
                if (sb_q.size() == 0) check("sv_unexpected", {24'h0, scan_code}, 32'hFFFF_FFFF);
                else check("scan_code", {24'h0, scan_code}, {24'h0, sb_q.pop_front()});
            end
            if (frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (scan_valid || frame_err) check("sv_fe_excl", {31'h0, scan_valid & frame_err}, 32'h0);
            for (int i = 0; i < 7; i++) if (key_press[i]) press_cnt[i]++;
        end
    end

    task automatic model_byte(input logic [7:0] b);
        logic [6:0] mk;
        sb_q.push_back(b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            mk = model_map(b);
            if (!m_ext) begin
                for (int i = 0; i < 7; i++) begin
                    if (mk[i]) begin
                        if (!m_brk && !m_held[i]) exp_press[i]++;
                        m_held[i] = ~m_brk;
                    end
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        last_edge_cyc = cyc;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop_bit);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_good ? ~(^b) : ^b);
        ps2_bit(stop_bit);
        ps2_data = 1'b1;
        repeat (40) @(posedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b1, 1'b1);
    endtask

    task automatic check_keys(input string tag);
        logic [6:0] bad;
        bad = '0;
        for (int i = 0; i < 7; i++) bad[i] = (press_cnt[i] != exp_press[i]);
        check({tag, "_held"}, {25'h0, key_held}, {25'h0, m_held});
        check({tag, "_press"}, {25'h0, bad}, 32'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_held"}, {25'h0, key_held}, 32'h0);
        check({tag, "_press"}, {25'h0, key_press}, 32'h0);
        check({tag, "_code"}, {24'h0, scan_code}, 32'h0);
        check({tag, "_valid"}, {31'h0, scan_valid}, 32'h0);
        check({tag, "_err"}, {31'h0, frame_err}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 7; i++) begin
            press_cnt[i] = 0;
            exp_press[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        repeat (5) @(posedge clk);

        send_good(8'h1D);
        check_keys("t1");
        check("t1_held_const", {25'h0, key_held}, 32'h01);

        send_good(8'h1A);
        check_keys("t2a");
        send_good(8'h1D);
        check_keys("t2b");
        send_good(8'hF0);
        send_good(8'h1D);
        check_keys("t2c");
        check("t2_held_const", {25'h0, key_held}, 32'h10);

        send_good(8'hE0);
        send_good(8'h75);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check_keys("t3");
        check("t3_sb_drained", sb_q.size(), 32'h0);

        fe0 = fe_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        exp_fe++;
        check("t4_stop_err", fe_cnt - fe0, 32'h1);
        check_keys("t4a");
        send_good(8'h5A);
        check_keys("t4b");

        fe0 = fe_cnt;
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h22, 1'b0, 1'b1);
        exp_fe++;
        check("t6_par_err", fe_cnt - fe0, 32'h1);
`else
        model_byte(8'h22);
        send_frame(8'h22, 1'b0, 1'b1);
        check("t6_par_ignored", fe_cnt - fe0, 32'h0);
`endif
        check_keys("t6");

        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        repeat (300) @(posedge clk);
        exp_fe++;
        check("t5_timeout_err", fe_cnt - fe0, 32'h1);
        check("t5_timeout_window",
              {31'h0, (fe_cyc - last_edge_cyc >= 190) && (fe_cyc - last_edge_cyc <= 240)}, 32'h1);
        send_good(8'h22);
        check_keys("t5");

        send_good(8'h1C);
        check_keys("t7a");
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        check_zero("t7_rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        m_held = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (5) @(posedge clk);
        send_good(8'h1B);
        check_keys("t7b");
        check("t7_held_const", {25'h0, key_held}, 32'h02);

        check("sb_empty", sb_q.size(), 32'h0);
        check("fe_total", fe_cnt, exp_fe);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
